// File: rtl/motor_frame_ctrl_if.sv
// Byte-receiver and motor-driver signal bundle for motor_frame_ctrl.
// The master modport is the controller side and the slave modport is the environment side.
interface motor_frame_ctrl_if;
  logic [7:0]  byte_in;
  logic        in_byte_tick;
  logic [2:0]  m_busy;
  logic [15:0] m_pos;
  logic [2:0]  m_load;
  logic        frame_done;
  logic        frame_err;
  logic        overrun;
  logic        dispatch_busy;

  modport master (
    input  byte_in, in_byte_tick, m_busy,
    output m_pos, m_load, frame_done, frame_err, overrun, dispatch_busy
  );

  modport slave (
    output byte_in, in_byte_tick, m_busy,
    input  m_pos, m_load, frame_done, frame_err, overrun, dispatch_busy
  );
endinterface

// File: rtl/motor_frame_ctrl.sv
// Frames SOF/6-byte/EOF position packets from a UART byte stream and dispatches them to three motors.
// Define FRAME_CHECKSUM_EN to require an XOR checksum byte between the data bytes and EOF.
module motor_frame_ctrl #(
  parameter logic [7:0]  SOF_BYTE       = 8'hFD,
  parameter logic [7:0]  EOF_BYTE       = 8'hFE,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned TO_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  motor_frame_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
`ifdef FRAME_CHECKSUM_EN
    RX_CHK,
`endif
    RX_EOF
  } rx_state_t;

  typedef enum logic {
    D_IDLE,
    D_ISSUE
  } disp_state_t;

  rx_state_t   r_rx_state, w_rx_next;
  disp_state_t r_d_state, w_d_next;

  logic [2:0]      r_byte_cnt;
  logic [7:0]      r_rx_data [6];
  logic [TO_W-1:0] r_to_cnt;
  logic [15:0]     r_pend_pos [3];
  logic [15:0]     r_act_pos [3];
  logic            r_pending;
  logic [1:0]      r_idx;
  logic [15:0]     r_pos;
  logic            r_frame_done;
  logic            r_frame_err;
  logic            r_overrun;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]      r_chk;
`endif

  logic       w_tick;
  logic [7:0] w_byte;
  logic       w_timeout;
  logic       w_commit;
  logic       w_bad;
  logic       w_take;
  logic       w_issue;

  assign w_tick    = bus.in_byte_tick;
  assign w_byte    = bus.byte_in;
  // A byte arriving in the same cycle as the limit restarts the window instead of timing out.
  assign w_timeout = (r_rx_state != RX_IDLE) && !w_tick && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign w_take    = (r_d_state == D_IDLE) && r_pending;
  assign w_issue   = (r_d_state == D_ISSUE) && !bus.m_busy[r_idx];

  // ---------------- receive FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_rx_next = r_rx_state;
    w_commit  = 1'b0;
    w_bad     = 1'b0;
    if (w_timeout) begin
      w_rx_next = RX_IDLE;
    end else if (w_tick) begin
      case (r_rx_state)
        RX_IDLE: if (w_byte == SOF_BYTE) w_rx_next = RX_DATA;
        RX_DATA: begin
          if (r_byte_cnt == 3'd5) begin
`ifdef FRAME_CHECKSUM_EN
            w_rx_next = RX_CHK;
`else
            w_rx_next = RX_EOF;
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        RX_CHK: begin
          if (w_byte == r_chk) begin
            w_rx_next = RX_EOF;
          end else begin
            w_bad     = 1'b1;
            w_rx_next = RX_IDLE;
          end
        end
`endif
        RX_EOF: begin
          if (w_byte == EOF_BYTE) w_commit = 1'b1;
          else                    w_bad    = 1'b1;
          w_rx_next = RX_IDLE;
        end
        default: w_rx_next = RX_IDLE;
      endcase
    end
  end

  // ---------------- receive datapath and pending buffer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the frame buffers are small register arrays, so they take the async reset like any other state.
      r_byte_cnt   <= '0;
      r_to_cnt     <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < 6; i++) r_rx_data[i] <= '0;
      for (int i = 0; i < 3; i++) r_pend_pos[i] <= '0;
`ifdef FRAME_CHECKSUM_EN
      r_chk        <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates keep every register reading the pre-edge values of the others.
      r_frame_done <= w_commit;
      r_frame_err  <= w_bad | w_timeout;
      // The dispatcher taking the old frame in the same cycle means nothing is lost.
      r_overrun    <= w_commit & r_pending & ~w_take;

      if (w_tick || r_rx_state == RX_IDLE) r_to_cnt <= '0;
      else                                 r_to_cnt <= r_to_cnt + 1'b1;

      if (w_tick && r_rx_state == RX_IDLE) begin
        r_byte_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
        r_chk      <= '0;
`endif
      end

      if (w_tick && !w_timeout && r_rx_state == RX_DATA) begin
        r_rx_data[r_byte_cnt] <= w_byte;
        r_byte_cnt            <= r_byte_cnt + 3'd1;
`ifdef FRAME_CHECKSUM_EN
        r_chk                 <= r_chk ^ w_byte;
`endif
      end

      if (w_commit) begin
        r_pend_pos[0] <= {r_rx_data[1], r_rx_data[0]};
        r_pend_pos[1] <= {r_rx_data[3], r_rx_data[2]};
        r_pend_pos[2] <= {r_rx_data[5], r_rx_data[4]};
      end

      if (w_commit)    r_pending <= 1'b1;
      else if (w_take) r_pending <= 1'b0;
    end
  end

  // ---------------- dispatch FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_d_state <= D_IDLE;
    else     r_d_state <= w_d_next;
  end

  always_comb begin
    w_d_next = r_d_state;
    case (r_d_state)
      D_IDLE:  if (r_pending) w_d_next = D_ISSUE;
      D_ISSUE: if (w_issue && r_idx == 2'd2) w_d_next = D_IDLE;
      default: w_d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_pos <= '0;
      for (int i = 0; i < 3; i++) r_act_pos[i] <= '0;
    end else begin
      if (w_take) begin
        r_idx <= '0;
        for (int i = 0; i < 3; i++) r_act_pos[i] <= r_pend_pos[i];
      end
      if (w_issue) begin
        r_idx <= r_idx + 2'd1;
        r_pos <= r_act_pos[r_idx];
      end
    end
  end

  // The load strobe follows busy combinationally so a free motor is loaded in the cycle it is reached.
  assign bus.m_load        = w_issue ? (3'b001 << r_idx) : 3'b000;
  assign bus.m_pos         = w_issue ? r_act_pos[r_idx] : r_pos;
  assign bus.frame_done    = r_frame_done;
  assign bus.frame_err     = r_frame_err;
  assign bus.overrun       = r_overrun;
  assign bus.dispatch_busy = (r_d_state != D_IDLE);

endmodule

// File: tb/tb_motor_frame_ctrl.sv
// Directed testbench for motor_frame_ctrl: framing, errors, timeout, busy stalls, overrun, reset.
// Inputs change 1 time unit after posedge; outputs are logged on negedge.
module tb_motor_frame_ctrl;
  localparam int T = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  motor_frame_ctrl_if bus();

  motor_frame_ctrl #(
    .SOF_BYTE(8'hFD), .EOF_BYTE(8'hFE), .TIMEOUT_CYCLES(T), .TO_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  ld;
    logic [15:0] pos;
    int          cyc;
  } load_t;

  load_t load_q[$];
  int done_cnt, err_cnt, ovr_cnt;
  int done_cyc, err_cyc, ovr_cyc;
  int last_tick_cyc;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_done) begin done_cnt++; done_cyc = cyc; end
      if (bus.frame_err)  begin err_cnt++;  err_cyc  = cyc; end
      if (bus.overrun)    begin ovr_cnt++;  ovr_cyc  = cyc; end
      if (bus.m_load != 3'b000) load_q.push_back('{bus.m_load, bus.m_pos, cyc});
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    load_q.delete();
    done_cnt = 0; err_cnt = 0; ovr_cnt = 0;
    done_cyc = -1; err_cyc = -1; ovr_cyc = -1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.byte_in      = b;
    bus.in_byte_tick = 1'b1;
    last_tick_cyc    = cyc;
    @(posedge clk); #1;
    bus.in_byte_tick = 1'b0;
  endtask

  // Sends SOF, the three positions low byte first, the checksum when enabled, and optionally an end byte.
  task automatic send_frame(input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] p3,
                            input logic [7:0] end_b, input bit with_end);
    logic [7:0] d [6];
    logic [7:0] x;
    d[0] = p1[7:0]; d[1] = p1[15:8]; d[2] = p2[7:0];
    d[3] = p2[15:8]; d[4] = p3[7:0]; d[5] = p3[15:8];
    x = 8'h00;
    send_byte(8'hFD);
    for (int i = 0; i < 6; i++) begin
      send_byte(d[i]);
      x = x ^ d[i];
    end
`ifdef FRAME_CHECKSUM_EN
    send_byte(x);
`endif
    if (with_end) send_byte(end_b);
  endtask

  task automatic test_reset();
    bus.byte_in = 8'h00; bus.in_byte_tick = 1'b0; bus.m_busy = 3'b000;
    rst = 1'b1;
    wait_cycles(3);
    checks++; if (bus.m_pos !== 16'h0000) begin errors++; $display("FAIL reset_m_pos got %h exp 0000", bus.m_pos); end
    checks++; if (bus.m_load !== 3'b000) begin errors++; $display("FAIL reset_m_load got %b exp 000", bus.m_load); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", bus.frame_done); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
    checks++; if (bus.dispatch_busy !== 1'b0) begin errors++; $display("FAIL reset_dispatch_busy got %b exp 0", bus.dispatch_busy); end
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_basic_frame();
    logic [2:0]  exp_ld  [3] = '{3'b001, 3'b010, 3'b100};
    logic [15:0] exp_pos [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    int e;
    clear_log();
    bus.m_busy = 3'b000;
    send_frame(16'h1234, 16'h5678, 16'h9ABC, 8'hFE, 1'b1);
    e = last_tick_cyc;
    wait_cycles(8);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    checks++; if (done_cyc !== e + 1) begin errors++; $display("FAIL basic_done_latency got %0d exp %0d", done_cyc, e + 1); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL basic_err_count got %0d exp 0", err_cnt); end
    checks++;
    if (load_q.size() !== 3) begin
      errors++; $display("FAIL basic_load_count got %0d exp 3", load_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (load_q[i].ld !== exp_ld[i] || load_q[i].pos !== exp_pos[i] || load_q[i].cyc !== e + 2 + i) begin
          errors++;
          $display("FAIL basic_load%0d got ld=%b pos=%h cyc=%0d exp ld=%b pos=%h cyc=%0d", i,
                   load_q[i].ld, load_q[i].pos, load_q[i].cyc, exp_ld[i], exp_pos[i], e + 2 + i);
        end
      end
    end
    checks++; if (bus.dispatch_busy !== 1'b0) begin errors++; $display("FAIL basic_dispatch_idle got %b exp 0", bus.dispatch_busy); end
  endtask

  task automatic test_bad_eof();
    logic [15:0] exp_pos [3] = '{16'h0201, 16'h0403, 16'h0605};
    int e;
    clear_log();
    send_frame(16'h0000, 16'h0000, 16'h0000, 8'hAA, 1'b1);
    e = last_tick_cyc;
    wait_cycles(6);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL bad_eof_err_count got %0d exp 1", err_cnt); end
    checks++; if (err_cyc !== e + 1) begin errors++; $display("FAIL bad_eof_err_cycle got %0d exp %0d", err_cyc, e + 1); end
    checks++; if (done_cnt !== 0 || load_q.size() !== 0) begin errors++; $display("FAIL bad_eof_no_commit got done=%0d loads=%0d exp 0/0", done_cnt, load_q.size()); end
    send_frame(16'h0201, 16'h0403, 16'h0605, 8'hFE, 1'b1);
    e = last_tick_cyc;
    wait_cycles(8);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bad_eof_recover_done got %0d exp 1", done_cnt); end
    checks++;
    if (load_q.size() !== 3) begin
      errors++; $display("FAIL bad_eof_recover_loads got %0d exp 3", load_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (load_q[i].pos !== exp_pos[i] || load_q[i].cyc !== e + 2 + i) begin
          errors++;
          $display("FAIL bad_eof_recover_load%0d got pos=%h cyc=%0d exp pos=%h cyc=%0d", i,
                   load_q[i].pos, load_q[i].cyc, exp_pos[i], e + 2 + i);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int t0, delta;
    clear_log();
    send_byte(8'hFD);
    send_byte(8'h11);
    send_byte(8'h22);
    t0 = last_tick_cyc;
    for (int k = 0; k < T + 100 && err_cnt == 0; k++) @(posedge clk);
    #1;
    delta = err_cyc - t0;
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL timeout_err_count got %0d exp 1", err_cnt); end
    checks++;
    if (delta < T + 1 || delta > T + 3) begin
      errors++; $display("FAIL timeout_delay got %0d exp %0d..%0d", delta, T + 1, T + 3);
    end
    for (int i = 0; i < 6; i++) send_byte(8'h33 + 8'(i * 8'h11));
    send_byte(8'h00);
    send_byte(8'hFE);
    wait_cycles(6);
    checks++;
    if (done_cnt !== 0 || err_cnt !== 1 || load_q.size() !== 0) begin
      errors++; $display("FAIL timeout_ignore got done=%0d err=%0d loads=%0d exp 0/1/0", done_cnt, err_cnt, load_q.size());
    end
  endtask

  task automatic test_busy_stall();
    int e, r;
    clear_log();
    bus.m_busy = 3'b010;
    send_frame(16'hC001, 16'hC002, 16'hC003, 8'hFE, 1'b1);
    e = last_tick_cyc;
    wait_cycles(6);
    checks++;
    if (load_q.size() !== 1) begin
      errors++; $display("FAIL stall_first_only got %0d loads exp 1", load_q.size());
    end else if (load_q[0].ld !== 3'b001 || load_q[0].pos !== 16'hC001 || load_q[0].cyc !== e + 2) begin
      errors++; $display("FAIL stall_first_load got ld=%b pos=%h cyc=%0d exp 001/C001/%0d",
                         load_q[0].ld, load_q[0].pos, load_q[0].cyc, e + 2);
    end
    checks++; if (bus.dispatch_busy !== 1'b1) begin errors++; $display("FAIL stall_dispatch_busy got %b exp 1", bus.dispatch_busy); end
    checks++; if (bus.m_pos !== 16'hC001) begin errors++; $display("FAIL stall_pos_hold got %h exp C001", bus.m_pos); end
    bus.m_busy = 3'b000;
    r = cyc;
    wait_cycles(6);
    checks++;
    if (load_q.size() !== 3) begin
      errors++; $display("FAIL stall_release_count got %0d exp 3", load_q.size());
    end else if (load_q[1].ld !== 3'b010 || load_q[1].pos !== 16'hC002 || load_q[1].cyc !== r ||
                 load_q[2].ld !== 3'b100 || load_q[2].pos !== 16'hC003 || load_q[2].cyc !== r + 1) begin
      errors++; $display("FAIL stall_release_loads got %b/%h/%0d %b/%h/%0d exp 010/C002/%0d 100/C003/%0d",
                         load_q[1].ld, load_q[1].pos, load_q[1].cyc, load_q[2].ld, load_q[2].pos, load_q[2].cyc, r, r + 1);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_pos [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h7777, 16'h8888, 16'h9999};
    int exp_off [6] = '{0, 1, 2, 4, 5, 6};
    int e, r;
    clear_log();
    bus.m_busy = 3'b111;
    send_frame(16'h1111, 16'h2222, 16'h3333, 8'hFE, 1'b1);
    send_frame(16'h4444, 16'h5555, 16'h6666, 8'hFE, 1'b1);
    wait_cycles(3);
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL overrun_early got %0d exp 0", ovr_cnt); end
    send_frame(16'h7777, 16'h8888, 16'h9999, 8'hFE, 1'b1);
    e = last_tick_cyc;
    wait_cycles(3);
    checks++; if (ovr_cnt !== 1 || ovr_cyc !== e + 1) begin errors++; $display("FAIL overrun_pulse got cnt=%0d cyc=%0d exp 1/%0d", ovr_cnt, ovr_cyc, e + 1); end
    checks++; if (done_cnt !== 3 || load_q.size() !== 0) begin errors++; $display("FAIL overrun_held got done=%0d loads=%0d exp 3/0", done_cnt, load_q.size()); end
    bus.m_busy = 3'b000;
    r = cyc;
    wait_cycles(12);
    checks++;
    if (load_q.size() !== 6) begin
      errors++; $display("FAIL overrun_load_count got %0d exp 6", load_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (load_q[i].pos !== exp_pos[i] || load_q[i].cyc !== r + exp_off[i] || load_q[i].ld !== 3'(3'b001 << (i % 3))) begin
          errors++; $display("FAIL overrun_load%0d got ld=%b pos=%h cyc=%0d exp pos=%h cyc=%0d", i,
                             load_q[i].ld, load_q[i].pos, load_q[i].cyc, exp_pos[i], r + exp_off[i]);
        end
      end
    end
  endtask

  // Commit of frame C lands in the same cycle the dispatcher takes pending frame B.
  task automatic test_back_to_back();
    logic [15:0] exp_pos [9] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                                 16'h6666, 16'h7777, 16'h8888, 16'h9999};
    int exp_off [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int r;
    clear_log();
    bus.m_busy = 3'b111;
    send_frame(16'h1111, 16'h2222, 16'h3333, 8'hFE, 1'b1);
    send_frame(16'h4444, 16'h5555, 16'h6666, 8'hFE, 1'b1);
    send_frame(16'h7777, 16'h8888, 16'h9999, 8'hFE, 1'b0);
    bus.m_busy = 3'b000;
    r = cyc;
    repeat (2) @(posedge clk);
    send_byte(8'hFE);
    wait_cycles(14);
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL b2b_no_overrun got %0d exp 0", ovr_cnt); end
    checks++; if (done_cnt !== 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", done_cnt); end
    checks++;
    if (load_q.size() !== 9) begin
      errors++; $display("FAIL b2b_load_count got %0d exp 9", load_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (load_q[i].pos !== exp_pos[i] || load_q[i].cyc !== r + exp_off[i]) begin
          errors++; $display("FAIL b2b_load%0d got pos=%h cyc=%0d exp pos=%h cyc=%0d", i,
                             load_q[i].pos, load_q[i].cyc, exp_pos[i], r + exp_off[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    bus.m_busy = 3'b111;
    send_frame(16'h5A5A, 16'hA5A5, 16'h0F0F, 8'hFE, 1'b1);
    send_byte(8'hFD);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    wait_cycles(2);
    checks++; if (bus.dispatch_busy !== 1'b0 || bus.m_load !== 3'b000) begin errors++; $display("FAIL rst_mid_outputs got busy=%b load=%b exp 0/000", bus.dispatch_busy, bus.m_load); end
    rst = 1'b0;
    bus.m_busy = 3'b000;
    clear_log();
    for (int i = 3; i <= 7; i++) send_byte(8'(i));
    send_byte(8'hFE);
    wait_cycles(8);
    checks++;
    if (load_q.size() !== 0 || done_cnt !== 0 || err_cnt !== 0) begin
      errors++; $display("FAIL rst_mid_discard got loads=%0d done=%0d err=%0d exp 0/0/0", load_q.size(), done_cnt, err_cnt);
    end
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] good [9] = '{8'hFD, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFE};
    int e;
    clear_log();
    for (int i = 0; i < 9; i++) send_byte(good[i]);
    wait_cycles(8);
    checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL chk_good got done=%0d err=%0d exp 1/0", done_cnt, err_cnt); end
    clear_log();
    for (int i = 0; i < 7; i++) send_byte(good[i]);
    send_byte(8'h00);
    e = last_tick_cyc;
    send_byte(8'hFE);
    wait_cycles(8);
    checks++; if (err_cnt !== 1 || err_cyc !== e + 1) begin errors++; $display("FAIL chk_bad_err got cnt=%0d cyc=%0d exp 1/%0d", err_cnt, err_cyc, e + 1); end
    checks++; if (done_cnt !== 0 || load_q.size() !== 0) begin errors++; $display("FAIL chk_bad_commit got done=%0d loads=%0d exp 0/0", done_cnt, load_q.size()); end
  endtask
`endif

  initial begin
    clear_log();
    test_reset();
    test_basic_frame();
    test_bad_eof();
    test_timeout();
    test_busy_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
